// File: rtl/theremin_pkg.sv
// Shared types and defaults for the theremin oscillator front end.
package theremin_pkg;

    // Period meter FSM: hunting for the first edge, or timing windows.
    typedef enum logic {
        ALIGN   = 1'b0,
        MEASURE = 1'b1
    } meter_state_t;

    // Minimum clk cycles between successive result pulses.
    localparam int HOLDOFF_DEFAULT = 4;

endpackage

// File: rtl/osc_period_meter_if.sv
// Result stream from the period meter into the log/LUT stage.
interface osc_period_meter_if #(
    parameter int OUT_B = 16
);
    logic [OUT_B-1:0] out_data;
    logic             out_valid;

    modport master (output out_data, output out_valid);
    modport slave  (input  out_data, input  out_valid);
endinterface

// File: rtl/edge_sync.sv
// Two-flop synchronizer for an asynchronous square wave, with rising-edge detect.
module edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise
);

    logic sync_q1;
    logic sync_q2;
    logic sync_q3;

    // Synchronize the input and keep one extra delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            sync_q3 <= 1'b0;
        end else begin
            sync_q1 <= async_in;
            sync_q2 <= sync_q1;
            sync_q3 <= sync_q2;
        end
    end

    assign rise = sync_q2 & ~sync_q3;

endmodule

// File: rtl/osc_period_meter.sv
// Measures clk cycles spanned by 2**AVG_LOG2 oscillator periods and
// emits rate-limited, saturating results.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ALIGN   | idle / waiting for the first synchronized rising edge
//   MEASURE | counting clk cycles and edges of the current window
module osc_period_meter
    import theremin_pkg::*;
#(
    parameter int OUT_B    = 16,
    parameter int AVG_LOG2 = 3,
    parameter int HOLDOFF  = HOLDOFF_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                osc_in,
    osc_period_meter_if.master  out_if
);

    localparam int HOLD_W = $clog2(HOLDOFF) + 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF - 1);
    localparam logic [OUT_B-1:0]  CNT_MAX   = '1;
    localparam int PER_LAST_I = (1 << AVG_LOG2) - 1;
    localparam logic [AVG_LOG2:0] PER_LAST  = PER_LAST_I[AVG_LOG2:0];

    meter_state_t        state;
    logic [OUT_B-1:0]    cyc_cnt;
    logic [AVG_LOG2:0]   per_cnt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic                pending;
    logic [OUT_B-1:0]    pend_data;
    logic [OUT_B-1:0]    out_data_q;
    logic                out_valid_q;

    logic                rise;
    logic                timeout;
    logic                win_done;
    logic                res_evt;
    logic [OUT_B-1:0]    res_val;

    edge_sync u_edge_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (osc_in),
        .rise     (rise)
    );

    // cyc_cnt holds (cycles elapsed since the window-start edge) - 1, so the
    // closing edge reports cyc_cnt + 1 and never needs to exceed all ones.
    // Timeout beats a coincident edge.
    always_comb begin
        timeout  = 1'b0;
        win_done = 1'b0;
        if (state == MEASURE && enable) begin
            timeout  = (cyc_cnt == CNT_MAX);
            win_done = rise && !timeout && (per_cnt == PER_LAST);
        end
        res_evt = timeout || win_done;
        res_val = timeout ? CNT_MAX : cyc_cnt + OUT_B'(1);
    end

    // Window FSM: the closing edge restarts the counters so it also opens the next window.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ALIGN;
            cyc_cnt <= '0;
            per_cnt <= '0;
        end else begin
            case (state)
                ALIGN: begin
                    cyc_cnt <= '0;
                    per_cnt <= '0;
                    if (enable && rise) begin
                        state <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (!enable || timeout) begin
                        state   <= ALIGN;
                        cyc_cnt <= '0;
                        per_cnt <= '0;
                    end else if (win_done) begin
                        cyc_cnt <= '0;
                        per_cnt <= '0;
                    end else begin
                        cyc_cnt <= cyc_cnt + OUT_B'(1);
                        if (rise) begin
                            per_cnt <= per_cnt + (AVG_LOG2 + 1)'(1);
                        end
                    end
                end
                default: state <= ALIGN;
            endcase
        end
    end

    // Output stage: rate-limit pulses, keeping only the newest result while held off.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            pending     <= 1'b0;
            pend_data   <= '0;
            hold_cnt    <= '0;
        end else begin
            out_valid_q <= 1'b0;
            if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - HOLD_W'(1);
            end
            if (!enable) begin
                pending <= 1'b0;
            end else if (res_evt || pending) begin
                if (hold_cnt == '0) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= res_evt ? res_val : pend_data;
                    pending     <= 1'b0;
                    hold_cnt    <= HOLD_LOAD;
                end else begin
                    pending <= 1'b1;
                    if (res_evt) begin
                        pend_data <= res_val;
                    end
                end
            end
        end
    end

    assign out_if.out_data  = out_data_q;
    assign out_if.out_valid = out_valid_q;

endmodule

// File: tb/tb_osc_period_meter.sv
// Bench for osc_period_meter: dut_a averages 1 period (16-bit count),
// dut_b averages 8 periods (12-bit count so the saturation case is short).
module tb_osc_period_meter;
    import theremin_pkg::*;

    localparam int HO = 4;

    logic clk = 1'b0;
    logic reset;
    logic enable;
    logic osc_a;
    logic osc_b;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    int exp_a_data[$];
    int exp_a_cyc[$];
    int exp_b_data[$];
    int exp_b_cyc[$];

    typedef struct {
        int sel;
        int period;
        int n_edges;
        int exp_data;
    } vec_t;

    vec_t vecs[6];

    osc_period_meter_if #(.OUT_B(16)) if_a ();
    osc_period_meter_if #(.OUT_B(12)) if_b ();

    osc_period_meter #(.OUT_B(16), .AVG_LOG2(0), .HOLDOFF(HO)) u_a (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .osc_in (osc_a),
        .out_if (if_a)
    );

    osc_period_meter #(.OUT_B(12), .AVG_LOG2(3), .HOLDOFF(HO)) u_b (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .osc_in (osc_b),
        .out_if (if_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input int sel, input int data, input int at_cyc);
        if (sel == 0) begin
            exp_a_data.push_back(data);
            exp_a_cyc.push_back(at_cyc);
        end else begin
            exp_b_data.push_back(data);
            exp_b_cyc.push_back(at_cyc);
        end
    endtask

    task automatic sb_check(input int sel, input int data);
        string nm;
        int ed;
        int ec;
        nm = (sel == 0) ? "dut_a" : "dut_b";
        if ((sel == 0 && exp_a_data.size() == 0) || (sel == 1 && exp_b_data.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL %s_unexpected_pulse: got data %0d at cycle %0d, required no pulse", nm, data, cyc);
            return;
        end
        if (sel == 0) begin
            ed = exp_a_data.pop_front();
            ec = exp_a_cyc.pop_front();
        end else begin
            ed = exp_b_data.pop_front();
            ec = exp_b_cyc.pop_front();
        end
        check_eq({nm, "_pulse_data"}, data, ed);
        check_eq({nm, "_pulse_cycle"}, cyc, ec);
    endtask

    // Every out_valid pulse is matched against the next expected result.
    always @(negedge clk) begin
        if (if_a.out_valid) sb_check(0, int'(if_a.out_data));
        if (if_b.out_valid) sb_check(1, int'(if_b.out_data));
    end

    // Expected pulses for a periodic stream whose edges are driven at e0 + k*period.
    // An edge driven in cycle E shows up as out_valid in cycle E+3 when not held off.
    task automatic plan_stream(input int sel, input int e0, input int period,
                               input int n, input int win, input int data);
        int  free_c;
        int  last_c;
        int  k;
        bit  pend;
        bit  res;
        free_c = 0;
        pend   = 1'b0;
        last_c = e0 + (n - 1) * period + 3;
        for (int c = e0 + win * period + 3; c <= last_c + HO; c++) begin
            k   = (c - e0 - 3) / period;
            res = ((c - e0 - 3) % period == 0) && (k % win == 0) && (c <= last_c);
            if ((res || pend) && c >= free_c) begin
                push_exp(sel, data, c);
                free_c = c + HO;
                pend   = 1'b0;
            end else if (res) begin
                pend = 1'b1;
            end
        end
    endtask

    task automatic set_osc(input int sel, input logic v);
        if (sel == 0) osc_a = v;
        else          osc_b = v;
    endtask

    task automatic drive_osc(input int sel, input int period, input int n);
        int hi;
        hi = (period / 2 > 0) ? period / 2 : 1;
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < period; j++) begin
                tick();
                if (j == 0)       set_osc(sel, 1'b1);
                else if (j == hi) set_osc(sel, 1'b0);
            end
        end
        set_osc(sel, 1'b0);
    endtask

    task automatic run_stream(input int sel, input int period, input int n, input int data);
        plan_stream(sel, cyc + 1, period, n, (sel == 0) ? 1 : 8, data);
        drive_osc(sel, period, n);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int t;
        t = 0;
        while ((exp_a_data.size() != 0 || exp_b_data.size() != 0) && t < budget) begin
            tick();
            t++;
        end
        if (exp_a_data.size() != 0 || exp_b_data.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_drain: got %0d pulses still outstanding, required 0",
                     name, exp_a_data.size() + exp_b_data.size());
            exp_a_data.delete();
            exp_a_cyc.delete();
            exp_b_data.delete();
            exp_b_cyc.delete();
        end
    endtask

    task automatic apply_reset();
        tick();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e;

        reset  = 1'b1;
        enable = 1'b0;
        osc_a  = 1'b0;
        osc_b  = 1'b0;

        vecs = '{
            '{0,  40,  5,   40},
            '{0,   7,  5,    7},
            '{0,   2,  9,    2},
            '{0,   3,  8,    3},
            '{1, 388, 17, 3104},
            '{1, 100,  9,  800}
        };

        repeat (3) tick();
        check_eq("reset_a_data",  int'(if_a.out_data),  0);
        check_eq("reset_a_valid", int'(if_a.out_valid), 0);
        check_eq("reset_b_data",  int'(if_b.out_data),  0);
        check_eq("reset_b_valid", int'(if_b.out_valid), 0);
        reset  = 1'b0;
        enable = 1'b1;

        foreach (vecs[i]) begin
            apply_reset();
            repeat (5) tick();
            run_stream(vecs[i].sel, vecs[i].period, vecs[i].n_edges, vecs[i].exp_data);
            wait_drain("vector", 200);
        end

        // Pending result is dropped when enable falls during holdoff.
        apply_reset();
        repeat (5) tick();
        e = cyc + 1;
        push_exp(0, 2, e + 5);
        tick(); osc_a = 1'b1;
        tick(); osc_a = 1'b0;
        tick(); osc_a = 1'b1;
        tick(); osc_a = 1'b0;
        tick(); osc_a = 1'b1;
        tick(); osc_a = 1'b0;
        tick();
        tick(); enable = 1'b0;
        repeat (10) tick();
        enable = 1'b1;
        wait_drain("pending_discard", 50);

        // Enable dropped mid-window: no pulse from the partial window, value held.
        apply_reset();
        repeat (5) tick();
        run_stream(0, 40, 3, 40);
        wait_drain("pre_disable", 50);
        enable = 1'b0;
        repeat (100) tick();
        check_eq("disable_hold_data", int'(if_a.out_data), 40);
        enable = 1'b1;
        run_stream(0, 40, 3, 40);
        wait_drain("post_enable", 200);

        // One-cycle reset mid-window clears outputs and forces a fresh ALIGN.
        apply_reset();
        repeat (5) tick();
        run_stream(0, 40, 2, 40);
        wait_drain("pre_reset", 50);
        repeat (20) tick();
        reset = 1'b1;
        tick();
        check_eq("midreset_a_data",  int'(if_a.out_data),  0);
        check_eq("midreset_a_valid", int'(if_a.out_valid), 0);
        reset = 1'b0;
        repeat (7) tick();
        run_stream(0, 40, 3, 40);
        wait_drain("post_reset", 200);

        // Stuck oscillator: saturated result once, edge on the timeout cycle ignored.
        apply_reset();
        repeat (5) tick();
        e = cyc + 1;
        push_exp(1, 4095, e + 4099);
        tick(); osc_b = 1'b1;
        tick(); osc_b = 1'b0;
        while (cyc < e + 4096) tick();
        osc_b = 1'b1;
        tick(); osc_b = 1'b0;
        repeat (300) tick();
        wait_drain("timeout", 50);
        check_eq("timeout_hold_data", int'(if_b.out_data), 4095);
        run_stream(1, 50, 9, 400);
        wait_drain("after_timeout", 200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
